// File: rtl/conversor_regbcd_regnbits_if.sv
// Handshake and data bundle between a controlling FSM and the BCD-to-binary converter.
// The master drives the start request and the BCD operand; the slave returns result and status.
// Width of the binary result is TAM_REG_BIN; the BCD operand is four bits wider.
interface conversor_regbcd_regnbits_if #(
  parameter int TAM_REG_BIN = 16
);
  logic                     inicio;
  logic [TAM_REG_BIN+3:0]   reg_BCD;
  logic [TAM_REG_BIN-1:0]   reg_binario;
  logic                     ocupado;
  logic                     listo;
  logic                     desborde;
  logic                     error_digito;

  modport master (
    output inicio, reg_BCD,
    input  reg_binario, ocupado, listo, desborde, error_digito
  );

  modport slave (
    input  inicio, reg_BCD,
    output reg_binario, ocupado, listo, desborde, error_digito
  );
endinterface

// File: rtl/conversor_regbcd_regnbits.sv
// Sequential BCD-to-binary converter using reverse double-dabble (shift right, then -3 on digits >= 8).
// Latency: listo in the cycle after edge k+N for a valid start at edge k; cycle after k for a bad digit.
// Backpressure: none; inicio is ignored while ocupado is high, no request queuing.
module conversor_regbcd_regnbits #(
  parameter int TAM_REG_BIN = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  conversor_regbcd_regnbits_if.slave    bus
);

  localparam int N  = TAM_REG_BIN;
  localparam int D  = (N + 4) / 4;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    CONVIERTE = 2'd1,
    FIN       = 2'd2
  } estado_t;

  estado_t           estado_q;
  logic [N+3:0]      bcd_q;
  logic [N-1:0]      bin_q;
  logic [CW-1:0]     cnt_q;
  logic [N-1:0]      reg_binario_q;
  logic              listo_q;
  logic              desborde_q;
  logic              error_digito_q;

  logic [2*N+3:0]    paso_d;
  logic              digito_invalido;

  // One iteration: shift {bcd, bin} right, then correct each BCD digit independently.
  always_comb begin
    paso_d = {bcd_q, bin_q} >> 1;
    for (int i = 0; i < D; i++) begin
      if (paso_d[N + 4*i + 3 -: 4] >= 4'd8) begin
        paso_d[N + 4*i + 3 -: 4] = paso_d[N + 4*i + 3 -: 4] - 4'd3;
      end
    end
  end

  // Flag any operand digit above 9 so the conversion can be skipped.
  always_comb begin
    digito_invalido = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (bus.reg_BCD[4*i + 3 -: 4] > 4'd9) begin
        digito_invalido = 1'b1;
      end
    end
  end

  // Control FSM with datapath; results only load on FIN entry and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q       <= REPOSO;
      bcd_q          <= '0;
      bin_q          <= '0;
      cnt_q          <= '0;
      reg_binario_q  <= '0;
      listo_q        <= 1'b0;
      desborde_q     <= 1'b0;
      error_digito_q <= 1'b0;
    end else begin
      listo_q <= 1'b0;
      case (estado_q)
        REPOSO: begin
          if (bus.inicio) begin
            bcd_q <= bus.reg_BCD;
            bin_q <= '0;
            cnt_q <= '0;
            if (digito_invalido) begin
              estado_q       <= FIN;
              listo_q        <= 1'b1;
              error_digito_q <= 1'b1;
              desborde_q     <= 1'b0;
              reg_binario_q  <= '0;
            end else begin
              estado_q <= CONVIERTE;
            end
          end
        end
        CONVIERTE: begin
          bcd_q <= paso_d[2*N+3:N];
          bin_q <= paso_d[N-1:0];
          cnt_q <= cnt_q + 1'b1;
          // The last shift leaves floor(value / 2^N) in the BCD remainder.
          if (cnt_q == CW'(N - 1)) begin
            estado_q       <= FIN;
            listo_q        <= 1'b1;
            reg_binario_q  <= paso_d[N-1:0];
            desborde_q     <= |paso_d[2*N+3:N];
            error_digito_q <= 1'b0;
          end
        end
        FIN: begin
          estado_q <= REPOSO;
        end
        default: begin
          estado_q <= REPOSO;
        end
      endcase
    end
  end

  assign bus.reg_binario  = reg_binario_q;
  assign bus.ocupado      = (estado_q != REPOSO);
  assign bus.listo        = listo_q;
  assign bus.desborde     = desborde_q;
  assign bus.error_digito = error_digito_q;

endmodule
